// File: rtl/branch_target_unit_pkg.sv
// Shared types for the branch target unit: entry kinds, table entry layout,
// sweep FSM states and the saturating counter step.
package p_hardisc;

   // Entry fields are sized for the widest supported configuration; the
   // unit fills unused upper bits with zero.
   localparam int TAG_MAX = 30;
   localparam int CNT_MAX = 8;

   typedef enum logic [1:0] {
      BRANCH = 2'b00,
      JUMP   = 2'b01,
      CALL   = 2'b10,
      RETURN = 2'b11
   } btu_kind_t;

   typedef struct packed {
      logic               valid;
      logic [TAG_MAX-1:0] tag;
      logic               ualig;
      btu_kind_t          kind;
      logic [19:0]        offset;
      logic [CNT_MAX-1:0] cnt;
   } btu_entry_t;

   typedef enum logic {
      IDLE  = 1'b0,
      FLUSH = 1'b1
   } btu_state_t;

   function automatic logic [CNT_MAX-1:0] cnt_step(input logic [CNT_MAX-1:0] c,
                                                   input logic up,
                                                   input logic [CNT_MAX-1:0] top);
      if (up) return (c == top) ? c : c + 1'b1;
      return (c == '0) ? c : c - 1'b1;
   endfunction

endpackage

// File: rtl/branch_target_unit_return_stack.sv
// Circular return-address stack; pushes past DEPTH overwrite the oldest
// address, pops on an empty stack are ignored.
module return_stack #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        push,
   input  logic        pop,
   input  logic [31:0] data,
   output logic [31:0] top,
   output logic        nonempty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [31:0]   mem [DEPTH];
   logic [PW-1:0] ptr;
   logic [PW:0]   count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr   <= '0;
         count <= '0;
      end else if (clr) begin
         ptr   <= '0;
         count <= '0;
      end else if (push) begin
         ptr <= ptr + 1'b1;
         if (count != (PW+1)'(DEPTH)) count <= count + 1'b1;
      end else if (pop && count != '0) begin
         ptr   <= ptr - 1'b1;
         count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !clr) mem[ptr + 1'b1] <= data;
   end

   assign top      = mem[ptr];
   assign nonempty = (count != '0);

endmodule

// File: rtl/branch_target_unit.sv
// Direct-mapped tagged branch target table with registered prediction and a
// one-entry-per-cycle flush sweep. Define PRED_RAS_EN for return prediction.
module branch_target_unit
   import p_hardisc::*;
#(
   parameter int ENTRIES   = 16,
   parameter int TAG_W     = 8,
   parameter int CNT_W     = 2,
   parameter int RAS_DEPTH = 4
) (
   input  logic        s_clk_i,
   input  logic        s_reset_i,
   input  logic        s_flush_i,
   output logic        s_busy_o,
   input  logic        s_fetch_valid_i,
   input  logic [31:1] s_fetch_add_i,
   input  logic        s_upd_valid_i,
   input  logic [1:0]  s_upd_kind_i,
   input  logic        s_upd_rvc_i,
   input  logic        s_upd_taken_i,
   input  logic [31:0] s_upd_base_i,
   input  logic [19:0] s_upd_offset_i,
   output logic        s_pred_valid_o,
   output logic [1:0]  s_pred_taken_o,
   output logic [31:0] s_pred_add_o
);

   localparam int IDX_W  = $clog2(ENTRIES);
   localparam int TAG_LO = IDX_W + 2;
   localparam logic [CNT_MAX-1:0] CNT_ONES = CNT_MAX'((1 << CNT_W) - 1);
   localparam logic [CNT_MAX-1:0] CNT_WEAK = CNT_MAX'(1 << (CNT_W - 1));

   btu_entry_t       tbl [ENTRIES];
   logic [ENTRIES-1:0] valid_q;
   btu_state_t       state;
   logic [IDX_W-1:0] flush_idx;
   logic             idle;

   assign idle     = (state == IDLE);
   assign s_busy_o = (state == FLUSH);

   // ---------------- lookup ----------------
   logic [IDX_W-1:0] f_idx;
   logic [TAG_W-1:0] f_tag;
   btu_entry_t       f_rd;
   logic             f_hit, f_taken;
   logic [31:0]      f_word, f_target;
   logic             ret_taken;
   logic [31:0]      ret_target;

   assign f_idx  = s_fetch_add_i[TAG_LO-1:2];
   assign f_tag  = s_fetch_add_i[TAG_LO+TAG_W-1:TAG_LO];
   assign f_rd   = tbl[f_idx];
   assign f_hit  = valid_q[f_idx] && f_rd.valid && (f_rd.tag == TAG_MAX'(f_tag));
   assign f_word = {s_fetch_add_i[31:2], 2'b00};

   always_comb begin
      f_taken  = 1'b0;
      f_target = f_word + {30'd0, f_rd.ualig, 1'b0}
               + {{11{f_rd.offset[19]}}, f_rd.offset, 1'b0};
      case (f_rd.kind)
         JUMP, CALL: f_taken = 1'b1;
         BRANCH:     f_taken = f_rd.cnt[CNT_W-1];
         RETURN: begin
            f_taken  = ret_taken;
            f_target = ret_target;
         end
         default:    f_taken = 1'b0;
      endcase
   end

   always_ff @(posedge s_clk_i or posedge s_reset_i) begin
      if (s_reset_i) begin
         s_pred_valid_o <= 1'b0;
         s_pred_taken_o <= 2'b00;
         s_pred_add_o   <= '0;
      end else begin
         s_pred_valid_o <= s_fetch_valid_i && idle;
         if (s_fetch_valid_i && idle && f_hit && f_taken) begin
            s_pred_taken_o <= f_rd.ualig ? 2'b10 : 2'b01;
            s_pred_add_o   <= f_target;
         end else begin
            s_pred_taken_o <= 2'b00;
         end
      end
   end

   // ---------------- update ----------------
   // An RVI instruction straddling a word is filed under the following word,
   // so its offset is rebased by one halfword.
   logic             u_fix, u_ualig, u_ok, u_hit, wr_en;
   logic [31:0]      u_addr;
   logic [19:0]      u_off;
   logic [IDX_W-1:0] u_idx;
   logic [TAG_W-1:0] u_tag;
   btu_kind_t        u_kind;
   btu_entry_t       u_rd, wr_entry;

   assign u_fix   = !s_upd_rvc_i && s_upd_base_i[1];
   assign u_ualig = s_upd_rvc_i && s_upd_base_i[1];
   assign u_addr  = u_fix ? s_upd_base_i + 32'd2 : s_upd_base_i;
   assign u_off   = u_fix ? s_upd_offset_i - 20'd1 : s_upd_offset_i;
   assign u_idx   = u_addr[TAG_LO-1:2];
   assign u_tag   = u_addr[TAG_LO+TAG_W-1:TAG_LO];
   assign u_kind  = btu_kind_t'(s_upd_kind_i);
   assign u_ok    = s_upd_valid_i && idle;
   assign u_rd    = tbl[u_idx];
   assign u_hit   = valid_q[u_idx] && u_rd.valid && (u_rd.tag == TAG_MAX'(u_tag));

   always_comb begin
      wr_en           = 1'b0;
      wr_entry.valid  = 1'b1;
      wr_entry.tag    = TAG_MAX'(u_tag);
      wr_entry.ualig  = u_ualig;
      wr_entry.kind   = u_kind;
      wr_entry.offset = u_off;
      wr_entry.cnt    = CNT_ONES;
      if (u_ok) begin
         if (u_kind != BRANCH) begin
            wr_en = 1'b1;
         end else if (u_hit) begin
            wr_en        = 1'b1;
            wr_entry.cnt = cnt_step(u_rd.cnt, s_upd_taken_i, CNT_ONES);
         end else if (s_upd_taken_i) begin
            wr_en        = 1'b1;
            wr_entry.cnt = CNT_WEAK;
         end
      end
   end

   always_ff @(posedge s_clk_i) begin
      if (wr_en) tbl[u_idx] <= wr_entry;
   end

   // ---------------- valid bits and sweep FSM ----------------
   always_ff @(posedge s_clk_i or posedge s_reset_i) begin
      if (s_reset_i) begin
         valid_q <= '0;
      end else if (state == FLUSH) begin
         valid_q[flush_idx] <= 1'b0;
      end else if (wr_en) begin
         valid_q[u_idx] <= 1'b1;
      end
   end

   always_ff @(posedge s_clk_i or posedge s_reset_i) begin
      if (s_reset_i) begin
         state     <= IDLE;
         flush_idx <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (s_flush_i) begin
                  state     <= FLUSH;
                  flush_idx <= '0;
               end
            end
            FLUSH: begin
               if (s_flush_i) begin
                  flush_idx <= '0;
               end else if (flush_idx == IDX_W'(ENTRIES - 1)) begin
                  state     <= IDLE;
                  flush_idx <= '0;
               end else begin
                  flush_idx <= flush_idx + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef PRED_RAS_EN
   logic [31:0] ras_top;
   logic        ras_nz;

   return_stack #(.DEPTH(RAS_DEPTH)) u_ras (
      .clk      (s_clk_i),
      .rst      (s_reset_i),
      .clr      (s_flush_i),
      .push     (u_ok && u_kind == CALL),
      .pop      (u_ok && u_kind == RETURN),
      .data     (s_upd_base_i + (s_upd_rvc_i ? 32'd2 : 32'd4)),
      .top      (ras_top),
      .nonempty (ras_nz)
   );

   assign ret_taken  = ras_nz;
   assign ret_target = ras_top;
`else
   localparam int unused_ras_depth = RAS_DEPTH;
   assign ret_taken  = 1'b0;
   assign ret_target = '0;
`endif

   logic unused_bits;
   assign unused_bits = ^{s_fetch_add_i[1], u_addr};

endmodule

// File: tb/tb_branch_target_unit.sv
// Directed bench for branch_target_unit: stimulus pushes expected predictions,
// a negedge monitor pops and compares whenever s_pred_valid_o is high.
module tb_branch_target_unit;

   localparam logic [1:0] K_BR = 2'b00, K_JMP = 2'b01, K_CALL = 2'b10, K_RET = 2'b11;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        busy;
   logic        fetch_valid = 1'b0;
   logic [31:1] fetch_add = '0;
   logic        upd_valid = 1'b0;
   logic [1:0]  upd_kind = '0;
   logic        upd_rvc = 1'b0;
   logic        upd_taken = 1'b0;
   logic [31:0] upd_base = '0;
   logic [19:0] upd_off = '0;
   logic        pred_valid;
   logic [1:0]  pred_taken;
   logic [31:0] pred_add;

   int tests = 0;
   int fails = 0;
   logic [33:0] exp_q [$];

   branch_target_unit #(.ENTRIES(16), .TAG_W(8), .CNT_W(2), .RAS_DEPTH(4)) dut (
      .s_clk_i         (clk),
      .s_reset_i       (rst),
      .s_flush_i       (flush),
      .s_busy_o        (busy),
      .s_fetch_valid_i (fetch_valid),
      .s_fetch_add_i   (fetch_add),
      .s_upd_valid_i   (upd_valid),
      .s_upd_kind_i    (upd_kind),
      .s_upd_rvc_i     (upd_rvc),
      .s_upd_taken_i   (upd_taken),
      .s_upd_base_i    (upd_base),
      .s_upd_offset_i  (upd_off),
      .s_pred_valid_o  (pred_valid),
      .s_pred_taken_o  (pred_taken),
      .s_pred_add_o    (pred_add)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every registered prediction must match the oldest expectation.
   always @(negedge clk) begin
      if (!rst && pred_valid) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_pred: got taken=%b add=0x%0h, expected no prediction",
                     pred_taken, pred_add);
         end else begin
            logic [33:0] e;
            e = exp_q.pop_front();
            check("pred_taken", {30'd0, pred_taken}, {30'd0, e[33:32]});
            check("pred_add", pred_add, e[31:0]);
         end
      end
   end

   task automatic drive(input logic fv, input logic [31:0] fa, input logic [1:0] et,
                        input logic [31:0] ea, input logic uv, input logic [1:0] k,
                        input logic rvc, input logic tk, input logic [31:0] b,
                        input logic [19:0] o);
      fetch_valid = fv;
      fetch_add   = fa[31:1];
      upd_valid   = uv;
      upd_kind    = k;
      upd_rvc     = rvc;
      upd_taken   = tk;
      upd_base    = b;
      upd_off     = o;
      if (fv) exp_q.push_back({et, ea});
      @(posedge clk);
      #1;
      fetch_valid = 1'b0;
      upd_valid   = 1'b0;
   endtask

   task automatic look(input logic [31:0] a, input logic [1:0] et, input logic [31:0] ea);
      drive(1'b1, a, et, ea, 1'b0, K_BR, 1'b0, 1'b0, 32'h0, 20'h0);
   endtask

   task automatic upd(input logic [1:0] k, input logic rvc, input logic tk,
                      input logic [31:0] b, input logic [19:0] o);
      drive(1'b0, 32'h0, 2'b00, 32'h0, 1'b1, k, rvc, tk, b, o);
   endtask

   // Start a sweep and count busy cycles; fetches and one update are issued
   // during the sweep and must have no effect.
   task automatic run_flush(input int restart, input int exp_n, input string name);
      int n;
      int sup;
      n   = 0;
      sup = 0;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush       = 1'b0;
      fetch_valid = 1'b1;
      fetch_add   = 31'h802;
      while (n < 100) begin
         @(negedge clk);
         if (!busy) break;
         n++;
         if (pred_valid) sup++;
         flush = (n == restart);
         if (n == 12) begin
            upd_valid = 1'b1; upd_kind = K_JMP; upd_rvc = 1'b0;
            upd_base  = 32'h5008; upd_off = 20'h4;
         end else begin
            upd_valid = 1'b0;
         end
      end
      fetch_valid = 1'b0;
      flush       = 1'b0;
      upd_valid   = 1'b0;
      check({name, "_busy_cycles"}, n, exp_n);
      check({name, "_pred_suppressed"}, sup, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // 1: reset state and first lookup
      repeat (3) @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_pred_valid", {31'd0, pred_valid}, 32'd0);
      check("rst_pred_taken", {30'd0, pred_taken}, 32'd0);
      check("rst_pred_add", pred_add, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      look(32'h1000, 2'b00, 32'h0);

      // 2: branch allocate, counter decay, saturation and recovery
      upd(K_BR, 1'b0, 1'b1, 32'h1002, 20'h1B);
      look(32'h1004, 2'b01, 32'h1038);
      upd(K_BR, 1'b0, 1'b0, 32'h1002, 20'h1B);
      upd(K_BR, 1'b0, 1'b0, 32'h1002, 20'h1B);
      look(32'h1004, 2'b00, 32'h1038);
      repeat (3) upd(K_BR, 1'b0, 1'b1, 32'h1002, 20'h1B);
      upd(K_BR, 1'b0, 1'b0, 32'h1002, 20'h1B);
      look(32'h1004, 2'b01, 32'h1038);
      upd(K_BR, 1'b0, 1'b0, 32'h1002, 20'h1B);
      look(32'h1004, 2'b00, 32'h1038);
      upd(K_BR, 1'b0, 1'b0, 32'h1800, 20'h5);
      look(32'h1800, 2'b00, 32'h1038);

      // 3: unaligned RVC jump, negative offset wrap, tag conflict
      upd(K_JMP, 1'b1, 1'b0, 32'h2002, 20'h10);
      look(32'h2000, 2'b10, 32'h2022);
      upd(K_JMP, 1'b0, 1'b0, 32'h0000, 20'hFFFFF);
      look(32'h0000, 2'b01, 32'hFFFF_FFFE);
      look(32'h2000, 2'b00, 32'hFFFF_FFFE);
      upd(K_RET, 1'b0, 1'b0, 32'h4020, 20'h8);
      look(32'h4020, 2'b00, 32'hFFFF_FFFE);

      // 4: flush sweep, suppression, dropped update, restart
      upd(K_BR, 1'b0, 1'b1, 32'h1002, 20'h1B);
      look(32'h1004, 2'b01, 32'h1038);
      run_flush(0, 16, "flush");
      look(32'h1004, 2'b00, 32'h1038);
      look(32'h5008, 2'b00, 32'h1038);
      run_flush(8, 24, "flush_restart");

      // 6: read-before-write at index 3, then reset mid-sweep
      upd(K_JMP, 1'b0, 1'b0, 32'h1038, 20'h2);
      upd(K_JMP, 1'b0, 1'b0, 32'h100C, 20'h10);
      look(32'h100C, 2'b01, 32'h102C);
      drive(1'b1, 32'h100C, 2'b01, 32'h102C, 1'b1, K_JMP, 1'b0, 1'b0, 32'h100C, 20'h40);
      look(32'h100C, 2'b01, 32'h108C);
      look(32'h1038, 2'b01, 32'h103C);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("midflush_rst_busy", {31'd0, busy}, 32'd0);
      check("midflush_rst_add", pred_add, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      look(32'h100C, 2'b00, 32'h0);
      look(32'h1038, 2'b00, 32'h0);

`ifdef PRED_RAS_EN
      // 5: return stack push/pop, overflow and underflow
      upd(K_RET, 1'b0, 1'b0, 32'h4020, 20'h8);
      upd(K_CALL, 1'b0, 1'b0, 32'h3000, 20'h40);
      look(32'h4020, 2'b01, 32'h3004);
      upd(K_CALL, 1'b0, 1'b0, 32'h3100, 20'h40);
      upd(K_CALL, 1'b0, 1'b0, 32'h3200, 20'h40);
      upd(K_CALL, 1'b0, 1'b0, 32'h3300, 20'h40);
      upd(K_CALL, 1'b0, 1'b0, 32'h3400, 20'h40);
      look(32'h4020, 2'b01, 32'h3404);
      upd(K_RET, 1'b0, 1'b0, 32'h4020, 20'h8);
      look(32'h4020, 2'b01, 32'h3304);
      upd(K_RET, 1'b0, 1'b0, 32'h4020, 20'h8);
      look(32'h4020, 2'b01, 32'h3204);
      upd(K_RET, 1'b0, 1'b0, 32'h4020, 20'h8);
      look(32'h4020, 2'b01, 32'h3104);
      upd(K_RET, 1'b0, 1'b0, 32'h4020, 20'h8);
      look(32'h4020, 2'b00, 32'h3104);
      upd(K_RET, 1'b0, 1'b0, 32'h4020, 20'h8);
      look(32'h4020, 2'b00, 32'h3104);
      upd(K_CALL, 1'b1, 1'b0, 32'h3502, 20'h40);
      look(32'h4020, 2'b01, 32'h3504);
`endif

      repeat (3) @(posedge clk);
      #1;
      check("queue_drained", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/branch_target_unit.md
Name: branch_target_unit

Overview:
- Parametrised successor to the core's branch/jump prediction front end.
- One direct-mapped, tagged target table holds branch, jump, call and return entries.
- Per-entry saturating direction counters of configurable width; prediction output is registered.
- Sequential flush sweep replaces single-cycle invalidate. Sits beside the fetch stage; updated from execute.

Parameters:
ENTRIES, 16, table depth, power of 2, >=2
TAG_W, 8, tag bits taken above the index bits of the word address
CNT_W, 2, direction counter width, >=1; taken when MSB set
RAS_DEPTH, 4, return stack depth, power of 2 (used only with optional feature)

Ports:
s_clk_i  in  1  clock
s_reset_i  in  1  asynchronous, active-high reset
s_flush_i  in  1  start full-table invalidation sweep
s_busy_o  out  1  sweep in progress
s_fetch_valid_i  in  1  lookup request
s_fetch_add_i  in  31  fetch halfword address [31:1]
s_upd_valid_i  in  1  update strobe
s_upd_kind_i  in  2  00 branch, 01 jump, 10 call, 11 return
s_upd_rvc_i  in  1  updating instruction is RVC
s_upd_taken_i  in  1  resolved direction; branches only
s_upd_base_i  in  32  instruction address
s_upd_offset_i  in  20  halfword target offset, signed
s_pred_valid_o  out  1  prediction registered this cycle
s_pred_taken_o  out  2  [0] aligned parcel, [1] unaligned parcel
s_pred_add_o  out  32  predicted target

Behaviour:
- Index = word address bits [log2(ENTRIES)+1:2]; tag = next TAG_W bits.
- Entry fields: valid, tag, ualig, kind, offset[19:0], cnt[CNT_W-1:0].
- Reset: all valid bits 0; FSM IDLE; all outputs 0. Payload fields are not reset.
- Lookup latency 1 cycle. s_pred_valid_o = registered (s_fetch_valid_i & FSM==IDLE).
- Hit = valid & tag match.
- Taken on hit when:
  - kind is jump or call, or
  - kind is branch and cnt MSB = 1, or
  - kind is return, but only per Optional Feature.
- Taken asserts s_pred_taken_o[ualig]; the other bit stays 0.
- Target = {word address,2'b00} + (ualig ? 2 : 0) + sext({offset,1'b0}), 32-bit wrap-around.
- On miss or not-taken: taken = 2'b00; s_pred_add_o holds its previous value.
- Update alignment rule:
  - RVI at base[1]=1: stored address = base+2, ualig = 0, offset = offset-1 (halfwords).
  - RVC at base[1]=1: ualig = 1, offset unchanged.
  - Otherwise ualig = 0.
- Update on hit:
  - Branch counter saturates up if taken, down if not taken.
  - Jump/call/return set cnt to all-ones.
  - Offset and kind are rewritten.
- Update on miss:
  - Replaces the entry.
  - Branch allocates only if taken, with cnt = 10..0 (weak taken).
  - Not-taken branch on miss: no write.
- Same-cycle lookup and update to the same index: lookup returns old contents (read-before-write).
- FSM:
  - IDLE -> FLUSH on s_flush_i.
  - FLUSH clears one valid bit per cycle, index 0..ENTRIES-1, then returns to IDLE. Sweep takes ENTRIES cycles.
  - s_busy_o = 1 while in FLUSH.
  - Updates are dropped and s_pred_valid_o = 0 while in FLUSH.
  - s_flush_i during FLUSH restarts the sweep at index 0.
- Reset mid-sweep: FSM forced to IDLE; all valid bits cleared.

Optional Feature:
- Macro: PRED_RAS_EN.
- Defined:
  - RAS_DEPTH-entry circular return-address stack.
  - Call update pushes base+(rvc?2:4). Overflow overwrites the oldest entry; count saturates at RAS_DEPTH.
  - Return update pops; underflow at count 0 is ignored.
  - Return-kind hit with count>0 predicts taken with target = top of stack.
  - Return-kind hit with count 0 predicts not taken.
  - Flush empties the stack.
- Undefined: no stack; return-kind entries never predict taken.

Decomposition:
- Package p_hardisc holds:
  - btu_kind_t enum (BRANCH, JUMP, CALL, RETURN).
  - btu_entry_t struct.
  - btu_state_t (IDLE, FLUSH).
- Sub-module return_stack, instantiated only under PRED_RAS_EN.

Test Plan:
1. Reset, then lookup 0x1000 -> s_pred_valid_o=1 next cycle, taken=00, add=0.
2. Taken branch update: base 0x1002, RVI, offset 0x1B (halfwords). Lookup 0x1004 -> taken=01, add=0x1038. Two not-taken updates (CNT_W=2) -> taken=00.
3. RVC jump update: base 0x2002, offset 0x10. Lookup 0x2000 -> taken=10, add=0x2022.
4. s_flush_i with ENTRIES=16 -> s_busy_o high 16 cycles, predictions suppressed. Prior hit at 0x1004 then misses. Flush re-asserted at cycle 8 extends busy to 24 cycles total.
5. PRED_RAS_EN: call update at 0x3000 (RVI), return entry at 0x4000 -> lookup 0x4000 gives add=0x3004. Five calls with RAS_DEPTH=4 then four returns -> last 4 addresses returned; fifth pop is ignored.
6. Same-cycle update and lookup at index 3 with reset asserted mid-flush -> old data returned; after reset all lookups miss.
